serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing `a - b` LSB-first, one bit per clock, on a single full-subtractor cell plus a borrow flip-flop. It is the subtraction counterpart to the team's adder datapath. It serves area-constrained paths where a WIDTH-bit parallel subtractor is not justified, and uses a start/done handshake toward its controller.

---
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Full-subtractor cell on the current LSBs.
  logic bit_d;
  logic brw_nx;
  assign bit_d  = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
  assign brw_nx = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted out of a_sr/b_sr, so keep copies for the flag.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_sr_d  = d_sr_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        d_sr_d = (d_sr_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
        brw_d  = brw_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = d_sr_d;
          bout_d  = brw_nx;
`ifdef SERIAL_SUB_OVF_EN
          // bit_d is the result MSB on the final step.
          ovf_d   = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_sr_q  <= d_sr_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       busy, done, bout, ovf;
  logic [7:0] diff;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Issues one request from a negedge with the DUT idle; returns at the done
  // cycle's negedge. lat = cycles after the accepting edge (-1 on timeout).
  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                        output int lat, output int busy_cnt, output int both);
    a = ai; b = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; busy_cnt = 0; both = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy && done) both++;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got %h want 00", diff); end
    n_tests++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout got %b want 0", bout); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_basic();
    int lat, bc, both;
    run_op(8'd100, 8'd37, lat, bc, both);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency got %0d want 8", lat); end
    n_tests++; if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    n_tests++; if (both !== 0) begin n_fail++; $display("FAIL basic_busy_and_done got %0d want 0", both); end
    n_tests++; if (diff !== 8'd63) begin n_fail++; $display("FAIL basic_diff got %0d want 63", diff); end
    n_tests++; if (bout !== 1'b0) begin n_fail++; $display("FAIL basic_bout got %b want 0", bout); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", ovf); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_after_done got done=%b busy=%b want 0/0", done, busy); end
    n_tests++; if (diff !== 8'd63) begin n_fail++; $display("FAIL basic_diff_hold got %0d want 63", diff); end
    $display("[TB] basic: 100-37 -> diff=%0d bout=%b ovf=%b lat=%0d", diff, bout, ovf, lat);
  endtask

  task automatic test_borrow();
    int lat, bc, both;
    run_op(8'h05, 8'h09, lat, bc, both);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL borrow_latency got %0d want 8", lat); end
    n_tests++; if (diff !== 8'hFC) begin n_fail++; $display("FAIL borrow_diff got %h want fc", diff); end
    n_tests++; if (bout !== 1'b1) begin n_fail++; $display("FAIL borrow_bout got %b want 1", bout); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL borrow_ovf got %b want 0", ovf); end
    @(negedge clk);
    $display("[TB] borrow: 05-09 -> diff=%h bout=%b ovf=%b", diff, bout, ovf);
  endtask

  task automatic test_ovf();
    int lat, bc, both;
    run_op(8'h80, 8'h01, lat, bc, both);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL ovf_latency got %0d want 8", lat); end
    n_tests++; if (diff !== 8'h7F) begin n_fail++; $display("FAIL ovf_diff got %h want 7f", diff); end
    n_tests++; if (bout !== 1'b0) begin n_fail++; $display("FAIL ovf_bout got %b want 0", bout); end
    n_tests++; if (ovf !== OVF_EN) begin n_fail++; $display("FAIL ovf_flag got %b want %b", ovf, OVF_EN); end
    @(negedge clk);
    n_tests++; if (ovf !== OVF_EN) begin n_fail++; $display("FAIL ovf_flag_hold got %b want %b", ovf, OVF_EN); end
    $display("[TB] ovf: 80-01 -> diff=%h bout=%b ovf=%b", diff, bout, ovf);
  endtask

  task automatic test_start_ignored();
    int n_done = 0;
    int first = -1;
    logic [7:0] d_seen = 8'hXX;
    logic       b_seen = 1'bx;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 2) begin
        a = 8'h10; b = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        if (first < 0) begin
          first = k; d_seen = diff; b_seen = bout;
        end
      end
      @(negedge clk);
    end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", n_done); end
    n_tests++; if (first !== 8) begin n_fail++; $display("FAIL ignore_latency got %0d want 8", first); end
    n_tests++; if (d_seen !== 8'h00) begin n_fail++; $display("FAIL ignore_diff got %h want 00", d_seen); end
    n_tests++; if (b_seen !== 1'b0) begin n_fail++; $display("FAIL ignore_bout got %b want 0", b_seen); end
    $display("[TB] start_ignored: FF-FF -> dones=%0d diff=%h", n_done, d_seen);
  endtask

  task automatic test_back_to_back();
    int lat1 = -1;
    int lat2 = -1;
    logic [7:0] d1 = 8'hXX;
    logic       bo1 = 1'bx;
    logic       busy0 = 1'b0;
    a = 8'd200; b = 8'd50; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat1 = k; d1 = diff; bo1 = bout;
        break;
      end
      @(negedge clk);
    end
    a = 8'd3; b = 8'd4;
    @(negedge clk);
    busy0 = busy;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat2 = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++; if (lat1 !== 8) begin n_fail++; $display("FAIL b2b_latency1 got %0d want 8", lat1); end
    n_tests++; if (d1 !== 8'd150) begin n_fail++; $display("FAIL b2b_diff1 got %0d want 150", d1); end
    n_tests++; if (bo1 !== 1'b0) begin n_fail++; $display("FAIL b2b_bout1 got %b want 0", bo1); end
    n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got %b want 1", busy0); end
    n_tests++; if (lat2 !== 8) begin n_fail++; $display("FAIL b2b_latency2 got %0d want 8", lat2); end
    n_tests++; if (diff !== 8'hFF) begin n_fail++; $display("FAIL b2b_diff2 got %h want ff", diff); end
    n_tests++; if (bout !== 1'b1) begin n_fail++; $display("FAIL b2b_bout2 got %b want 1", bout); end
    @(negedge clk);
    $display("[TB] back_to_back: 200-50 -> %0d, 3-4 -> %h bout=%b", d1, diff, bout);
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    int lat, bc, both;
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
    n_tests++; if (diff !== 8'h00) begin n_fail++; $display("FAIL midrst_diff got %h want 00", diff); end
    n_tests++; if (bout !== 1'b0) begin n_fail++; $display("FAIL midrst_bout got %b want 0", bout); end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d want 0", n_done); end
    run_op(8'd9, 8'd9, lat, bc, both);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL midrst_after_latency got %0d want 8", lat); end
    n_tests++; if (diff !== 8'h00) begin n_fail++; $display("FAIL midrst_after_diff got %h want 00", diff); end
    n_tests++; if (bout !== 1'b0) begin n_fail++; $display("FAIL midrst_after_bout got %b want 0", bout); end
    @(negedge clk);
    $display("[TB] reset_mid: aborted op, then 9-9 -> diff=%h bout=%b", diff, bout);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ovf();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
